// File: rtl/inst_issue_buffer_pkg.sv
// Shared definitions for the instruction issue buffer: default depth, the
// branch opcode/funct/rt encodings of the execute stage, issue-hint values
// and the queue entry layout.
package inst_issue_buffer_pkg;

    localparam int IB_DEPTH = 16;

    // Primary opcodes
    localparam logic [5:0] EXE_SPECIAL_OP = 6'b000000;
    localparam logic [5:0] EXE_REGIMM_OP  = 6'b000001;
    localparam logic [5:0] EXE_J_OP       = 6'b000010;
    localparam logic [5:0] EXE_JAL_OP     = 6'b000011;
    localparam logic [5:0] EXE_BEQ_OP     = 6'b000100;
    localparam logic [5:0] EXE_BNE_OP     = 6'b000101;
    localparam logic [5:0] EXE_BLEZ_OP    = 6'b000110;
    localparam logic [5:0] EXE_BGTZ_OP    = 6'b000111;

    // SPECIAL funct codes for register jumps
    localparam logic [5:0] EXE_JR_FUNC    = 6'b001000;
    localparam logic [5:0] EXE_JALR_FUNC  = 6'b001001;

    // REGIMM rt codes for the sign branches
    localparam logic [4:0] EXE_BLTZ_RT    = 5'b00000;
    localparam logic [4:0] EXE_BGEZ_RT    = 5'b00001;
    localparam logic [4:0] EXE_BLTZAL_RT  = 5'b10000;
    localparam logic [4:0] EXE_BGEZAL_RT  = 5'b10001;

    // Issue hint values
    localparam logic SINGLE_ISSUE = 1'b0;
    localparam logic DUAL_ISSUE   = 1'b1;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_branch;
        logic        ds;
    } ib_entry_t;

endpackage

// File: rtl/inst_issue_buffer_ib_branch_detect.sv
// ib_branch_detect: flags control-transfer instructions that own a delay slot
// (J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ(AL), BGEZ(AL)).
module ib_branch_detect (
    input  logic [31:0] inst_i,
    output logic        is_branch_o
);
    import inst_issue_buffer_pkg::*;

    // Match the whole word against the branch encodings; other fields are don't-care
    always_comb begin
        is_branch_o = 1'b0;
        casez (inst_i)
            {EXE_J_OP,       {26{1'b?}}},
            {EXE_JAL_OP,     {26{1'b?}}},
            {EXE_BEQ_OP,     {26{1'b?}}},
            {EXE_BNE_OP,     {26{1'b?}}},
            {EXE_BLEZ_OP,    {26{1'b?}}},
            {EXE_BGTZ_OP,    {26{1'b?}}},
            {EXE_SPECIAL_OP, {20{1'b?}}, EXE_JR_FUNC},
            {EXE_SPECIAL_OP, {20{1'b?}}, EXE_JALR_FUNC},
            {EXE_REGIMM_OP,  {5{1'b?}}, EXE_BLTZ_RT,   {16{1'b?}}},
            {EXE_REGIMM_OP,  {5{1'b?}}, EXE_BGEZ_RT,   {16{1'b?}}},
            {EXE_REGIMM_OP,  {5{1'b?}}, EXE_BLTZAL_RT, {16{1'b?}}},
            {EXE_REGIMM_OP,  {5{1'b?}}, EXE_BGEZAL_RT, {16{1'b?}}}: is_branch_o = 1'b1;
            default: is_branch_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_issue_buffer.sv
// inst_issue_buffer: circular instruction queue between the I-cache and the
// decode stage. Takes up to two fetched words per cycle, presents the two
// oldest with PC and delay-slot tag, and keeps a pending delay slot alive
// across a taken-branch redirect.
// Optional feature macro: IB_DUAL_ISSUE_EN enables the slot-2 outputs, the
// issue hint and two-entry pops; without it decode sees one entry per cycle.
module inst_issue_buffer
    import inst_issue_buffer_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        branch_flag_i,
    input  logic        push1_i,
    input  logic        push2_i,
    input  logic [31:0] push_inst1_i,
    input  logic [31:0] push_inst2_i,
    input  logic [31:0] push_pc_i,
    input  logic        stall_i,
    input  logic [1:0]  pop_num_i,
    output logic [31:0] inst1_o,
    output logic [31:0] inst2_o,
    output logic [31:0] pc1_o,
    output logic [31:0] pc2_o,
    output logic        valid1_o,
    output logic        valid2_o,
    output logic        is_in_delayslot1_o,
    output logic        is_in_delayslot2_o,
    output logic        issue_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam logic [PTR_W:0] OCC_ZERO = (PTR_W+1)'(0);
    localparam logic [PTR_W:0] OCC_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] OCC_TWO  = (PTR_W+1)'(2);
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH - 1);

    ib_entry_t        mem_q [DEPTH];
    ib_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             ds_wait_q, ds_wait_d;
    logic             keep_one_q, keep_one_d;
    logic             last_br_q, last_br_d;

    logic             br1_s, br2_s;
    logic             full_s, empty_s;
    logic             push_ok_s, push_two_s;
    logic [1:0]       push_cnt_s, pop_req_s, pop_cnt_s;
    logic [PTR_W:0]   pop_req_ext_s;
    logic [PTR_W-1:0] head1_s, tail1_s, last_pop_idx_s;

    ib_branch_detect u_br1 (.inst_i(push_inst1_i), .is_branch_o(br1_s));
    ib_branch_detect u_br2 (.inst_i(push_inst2_i), .is_branch_o(br2_s));

    assign full_s         = (occ_q >= OCC_FULL);
    assign empty_s        = (occ_q == OCC_ZERO);
    assign head1_s        = head_q + PTR_W'(1);
    assign tail1_s        = tail_q + PTR_W'(1);
    assign last_pop_idx_s = head_q + PTR_W'(pop_cnt_s) - PTR_W'(1);
    assign pop_req_ext_s  = (PTR_W+1)'(pop_req_s);
    assign full_o         = full_s;
    assign empty_o        = empty_s;

    // Requested pop count, then clamped to what is actually queued
    always_comb begin
        pop_req_s = 2'd0;
        if (stall_i) begin
            pop_req_s = 2'd0;
        end else begin
`ifdef IB_DUAL_ISSUE_EN
            case (pop_num_i)
                2'd0:    pop_req_s = 2'd0;
                2'd1:    pop_req_s = 2'd1;
                default: pop_req_s = 2'd2;
            endcase
`else
            pop_req_s = (pop_num_i != 2'd0) ? 2'd1 : 2'd0;
`endif
        end
        pop_cnt_s = (pop_req_ext_s > occ_q) ? occ_q[1:0] : pop_req_s;
    end

    // Queue next-state: flush, redirect handling, push writes and pops
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        ds_wait_d  = ds_wait_q;
        keep_one_d = keep_one_q;
        last_br_d  = last_br_q;
        mem_d      = mem_q;
        push_ok_s  = 1'b0;
        push_two_s = 1'b0;
        push_cnt_s = 2'd0;
        if (flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            occ_d      = '0;
            ds_wait_d  = 1'b0;
            keep_one_d = 1'b0;
            last_br_d  = 1'b0;
        end else begin
            // A redirect only lets the pending delay slot in (slot 1 into an empty queue)
            if (branch_flag_i) begin
                push_ok_s = push1_i & ~full_s & keep_one_q & empty_s;
            end else begin
                push_ok_s = push1_i & ~full_s;
            end
            push_two_s = push_ok_s & push2_i & ~keep_one_q;
            push_cnt_s = {1'b0, push_ok_s} + {1'b0, push_two_s};
            if (push_ok_s) begin
                mem_d[tail_q] = '{inst: push_inst1_i, pc: push_pc_i,
                                  is_branch: br1_s, ds: last_br_q};
                last_br_d  = br1_s;
                keep_one_d = 1'b0;
                if (push_two_s) begin
                    mem_d[tail1_s] = '{inst: push_inst2_i, pc: push_pc_i + 32'd4,
                                       is_branch: br2_s, ds: br1_s};
                    last_br_d      = br2_s;
                end else begin
                    mem_d[tail1_s] = mem_q[tail1_s];
                end
            end else begin
                last_br_d = last_br_q;
            end
            if (branch_flag_i) begin
                if (ds_wait_q && !empty_s) begin
                    // Head is the delay slot of the branch just issued: keep it alone
                    occ_d  = OCC_ONE;
                    tail_d = head1_s;
                end else begin
                    head_d = tail_q;
                    tail_d = tail_q + PTR_W'(push_cnt_s);
                    occ_d  = (PTR_W+1)'(push_cnt_s);
                    if (ds_wait_q) begin
                        keep_one_d = ~push_ok_s;
                    end else begin
                        keep_one_d = keep_one_q & ~push_ok_s;
                    end
                end
            end else begin
                head_d = head_q + PTR_W'(pop_cnt_s);
                tail_d = tail_q + PTR_W'(push_cnt_s);
                occ_d  = occ_q + (PTR_W+1)'(push_cnt_s) - (PTR_W+1)'(pop_cnt_s);
                if (pop_cnt_s != 2'd0) begin
                    ds_wait_d = mem_q[last_pop_idx_s].is_branch;
                end else begin
                    ds_wait_d = ds_wait_q;
                end
            end
        end
    end

    // State and storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            ds_wait_q  <= 1'b0;
            keep_one_q <= 1'b0;
            last_br_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            ds_wait_q  <= ds_wait_d;
            keep_one_q <= keep_one_d;
            last_br_q  <= last_br_d;
            mem_q      <= mem_d;
        end
    end

    // Present the two oldest entries, zeroed when not present
    always_comb begin
        inst1_o            = 32'd0;
        pc1_o              = 32'd0;
        valid1_o           = 1'b0;
        is_in_delayslot1_o = 1'b0;
        inst2_o            = 32'd0;
        pc2_o              = 32'd0;
        valid2_o           = 1'b0;
        is_in_delayslot2_o = 1'b0;
        issue_o            = SINGLE_ISSUE;
        if (!empty_s) begin
            inst1_o            = mem_q[head_q].inst;
            pc1_o              = mem_q[head_q].pc;
            valid1_o           = 1'b1;
            is_in_delayslot1_o = mem_q[head_q].ds;
        end else begin
            valid1_o = 1'b0;
        end
`ifdef IB_DUAL_ISSUE_EN
        if (occ_q >= OCC_TWO) begin
            inst2_o            = mem_q[head1_s].inst;
            pc2_o              = mem_q[head1_s].pc;
            valid2_o           = 1'b1;
            is_in_delayslot2_o = mem_q[head1_s].ds;
            // A slot-2 branch without its delay slot queued must go alone
            issue_o = (mem_q[head1_s].is_branch && (occ_q == OCC_TWO)) ? SINGLE_ISSUE : DUAL_ISSUE;
        end else begin
            valid2_o = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_inst_issue_buffer.sv
// Self-checking bench for inst_issue_buffer: directed scenarios plus a long
// random run, all compared against a queue-based reference model.
// Follows IB_DUAL_ISSUE_EN the same way as the design build.
module tb_inst_issue_buffer;

`ifdef IB_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam int DEPTH = 16;

    localparam logic [31:0] ADDU = 32'h0085_1021;
    localparam logic [31:0] BEQ  = 32'h1085_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0, branch_flag_i = 1'b0;
    logic        push1_i = 1'b0, push2_i = 1'b0;
    logic [31:0] push_inst1_i = 32'd0, push_inst2_i = 32'd0, push_pc_i = 32'd0;
    logic        stall_i = 1'b0;
    logic [1:0]  pop_num_i = 2'd0;
    logic [31:0] inst1_o, inst2_o, pc1_o, pc2_o;
    logic        valid1_o, valid2_o, ds1_o, ds2_o, issue_o, full_o, empty_o;
    logic [134:0] obs_s;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        bit          br;
        bit          ds;
    } m_entry_t;

    m_entry_t mq[$];
    bit m_ds_wait = 1'b0, m_keep_one = 1'b0, m_last_br = 1'b0;

    inst_issue_buffer dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .branch_flag_i(branch_flag_i),
        .push1_i(push1_i), .push2_i(push2_i),
        .push_inst1_i(push_inst1_i), .push_inst2_i(push_inst2_i), .push_pc_i(push_pc_i),
        .stall_i(stall_i), .pop_num_i(pop_num_i),
        .inst1_o(inst1_o), .inst2_o(inst2_o), .pc1_o(pc1_o), .pc2_o(pc2_o),
        .valid1_o(valid1_o), .valid2_o(valid2_o),
        .is_in_delayslot1_o(ds1_o), .is_in_delayslot2_o(ds2_o),
        .issue_o(issue_o), .full_o(full_o), .empty_o(empty_o)
    );

    assign obs_s = {inst1_o, inst2_o, pc1_o, pc2_o, valid1_o, valid2_o,
                    ds1_o, ds2_o, issue_o, full_o, empty_o};

    always #5 clk = ~clk;

    // Reference decoder written from the instruction set listing
    function automatic bit ref_is_branch(input logic [31:0] w);
        int op, fn, rt;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        rt = int'(w[20:16]);
        if (op >= 2 && op <= 7) return 1'b1;
        if (op == 0) return (fn == 8) || (fn == 9);
        if (op == 1) return (rt == 0) || (rt == 1) || (rt == 16) || (rt == 17);
        return 1'b0;
    endfunction

    function automatic logic [134:0] model_outputs();
        logic [31:0] i1, i2, p1, p2;
        logic v1, v2, d1, d2, is;
        i1 = 32'd0; i2 = 32'd0; p1 = 32'd0; p2 = 32'd0;
        v1 = 1'b0; v2 = 1'b0; d1 = 1'b0; d2 = 1'b0; is = 1'b0;
        if (mq.size() >= 1) begin
            i1 = mq[0].inst; p1 = mq[0].pc; v1 = 1'b1; d1 = mq[0].ds;
        end
        if (DUAL && mq.size() >= 2) begin
            i2 = mq[1].inst; p2 = mq[1].pc; v2 = 1'b1; d2 = mq[1].ds;
            is = !(mq[1].br && mq.size() == 2);
        end
        return {i1, i2, p1, p2, v1, v2, d1, d2, is,
                logic'(mq.size() >= DEPTH - 1), logic'(mq.size() == 0)};
    endfunction

    // Advance the model by one clock using the currently driven inputs
    task automatic model_step();
        int n;
        bit full_pre, empty_pre, ko_old, accept;
        m_entry_t e;
        if (rst || flush_i) begin
            mq.delete();
            m_ds_wait = 1'b0; m_keep_one = 1'b0; m_last_br = 1'b0;
        end else begin
            full_pre  = (mq.size() >= DEPTH - 1);
            empty_pre = (mq.size() == 0);
            ko_old    = m_keep_one;
            if (branch_flag_i) begin
                if (m_ds_wait && !empty_pre) begin
                    while (mq.size() > 1) void'(mq.pop_back());
                end else begin
                    mq.delete();
                    if (m_ds_wait) m_keep_one = 1'b1;
                end
                accept = push1_i && !full_pre && ko_old && empty_pre;
            end else begin
                n = stall_i ? 0 : int'(pop_num_i);
                if (!DUAL && n > 1) n = 1;
                if (n > mq.size()) n = mq.size();
                if (n > 0) m_ds_wait = mq[n-1].br;
                repeat (n) void'(mq.pop_front());
                accept = push1_i && !full_pre;
            end
            if (accept) begin
                e.inst = push_inst1_i; e.pc = push_pc_i;
                e.br = ref_is_branch(push_inst1_i); e.ds = m_last_br;
                mq.push_back(e);
                m_last_br = e.br;
                if (ko_old) begin
                    m_keep_one = 1'b0;
                end else if (push2_i) begin
                    e.inst = push_inst2_i; e.pc = push_pc_i + 32'd4;
                    e.ds = m_last_br; e.br = ref_is_branch(push_inst2_i);
                    mq.push_back(e);
                    m_last_br = e.br;
                end
            end
        end
    endtask

    task automatic cyc(input bit p1, input bit p2, input logic [31:0] i1,
                       input logic [31:0] i2, input logic [31:0] pc, input bit st,
                       input logic [1:0] pn, input bit br, input bit fl);
        rst = 1'b0; push1_i = p1; push2_i = p2 & p1;
        push_inst1_i = i1; push_inst2_i = i2; push_pc_i = pc;
        stall_i = st; pop_num_i = pn; branch_flag_i = br; flush_i = fl;
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_inst();
        logic [31:0] tbl [14];
        tbl = '{32'h0085_1021, 32'h1085_0004, 32'h0800_0040, 32'h0C00_0040,
                32'h03E0_0008, 32'h0040_F809, 32'h1485_0004, 32'h1880_0004,
                32'h1C80_0004, 32'h0480_0004, 32'h0491_0004, 32'h0488_0004,
                32'h8C82_0000, 32'h0000_000C};
        if ($urandom_range(0, 7) == 0) return $urandom;
        return tbl[$urandom_range(0, 13)];
    endfunction

    task automatic test_reset();
        rst = 1'b1; push1_i = 1'b1; push2_i = 1'b1; push_inst1_i = BEQ;
        push_inst2_i = ADDU; push_pc_i = 32'h40; pop_num_i = 2'd1;
        model_step();
        @(posedge clk); #1;
        n_tests++;
        if (obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", obs_s, model_outputs());
        end
        n_tests++;
        if ({empty_o, full_o, valid1_o} !== 3'b100) begin
            n_fail++; $display("FAIL reset_flags: got %b want 100", {empty_o, full_o, valid1_o});
        end
    endtask

    task automatic test_dual_push();
        cyc(1, 1, ADDU, ADDU, 32'h100, 0, 2'd0, 0, 0);
        n_tests++;
        if (obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL dual_push: got %h want %h", obs_s, model_outputs());
        end
        n_tests++;
        if ({valid1_o, pc1_o} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL dual_push_pc1: got %h want 1_00000100", {valid1_o, pc1_o});
        end
    endtask

    task automatic test_delay_slot();
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
        cyc(1, 0, BEQ, ADDU, 32'h200, 1, 2'd0, 0, 0);
        n_tests++;
        if (issue_o !== 1'b0 || obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL ds_branch_alone: got %h want %h", obs_s, model_outputs());
        end
        cyc(1, 0, ADDU, BEQ, 32'h204, 1, 2'd0, 0, 0);
        n_tests++;
        if (obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL ds_tagged: got %h want %h", obs_s, model_outputs());
        end
    endtask

    task automatic test_keep_one();
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
        cyc(1, 0, BEQ, 0, 32'h200, 0, 2'd0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'd1, 0, 0);
        cyc(1, 1, ADDU, ADDU, 32'h208, 0, 2'd0, 1, 0);
        n_tests++;
        if (empty_o !== 1'b1 || obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL keep_one_redirect: got %h want %h", obs_s, model_outputs());
        end
        cyc(1, 1, ADDU, ADDU, 32'h208, 1, 2'd0, 0, 0);
        n_tests++;
        if ({ds1_o, pc1_o} !== {1'b1, 32'h208} || obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL keep_one_slot1: got %h want %h", obs_s, model_outputs());
        end
        cyc(1, 1, ADDU, BEQ, 32'h20C, 1, 2'd0, 0, 0);
        n_tests++;
        if (obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL keep_one_after: got %h want %h", obs_s, model_outputs());
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 2'd1, 0, 0);
            n_tests++;
            if (obs_s !== model_outputs()) begin
                n_fail++; $display("FAIL keep_one_drain%0d: got %h want %h", i, obs_s, model_outputs());
            end
        end
    endtask

    task automatic test_full();
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 1, pick_inst(), pick_inst(), 32'h1000 + 8*i, 0, 2'd0, 0, 0);
        cyc(1, 0, ADDU, 0, 32'h1038, 0, 2'd0, 0, 0);
        n_tests++;
        if (full_o !== 1'b1 || obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL full_at_15: got %h want %h", obs_s, model_outputs());
        end
        cyc(1, 1, BEQ, BEQ, 32'h2000, 1, 2'd0, 0, 0);
        n_tests++;
        if (full_o !== 1'b1 || obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL full_drop: got %h want %h", obs_s, model_outputs());
        end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 2'd1, 0, 0);
            n_tests++;
            if (obs_s !== model_outputs()) begin
                n_fail++; $display("FAIL full_drain%0d: got %h want %h", i, obs_s, model_outputs());
            end
        end
    endtask

    task automatic test_wrap();
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 1, ADDU, ADDU, 32'h3000 + 8*i, 0, 2'd0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 2'd1, 0, 0);
        cyc(1, 0, ADDU, 0, 32'h3038, 0, 2'd0, 0, 0);
        cyc(1, 1, ADDU, ADDU, 32'h4000, 0, 2'd2, 0, 0);
        n_tests++;
        if (obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL wrap_push_pop: got %h want %h", obs_s, model_outputs());
        end
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 2'd1, 0, 0);
            n_tests++;
            if (obs_s !== model_outputs()) begin
                n_fail++; $display("FAIL wrap_order%0d: got %h want %h", i, obs_s, model_outputs());
            end
        end
    endtask

    task automatic test_flush_priority();
        cyc(1, 1, BEQ, ADDU, 32'h500, 0, 2'd0, 0, 0);
        cyc(1, 1, ADDU, ADDU, 32'h508, 0, 2'd1, 0, 0);
        cyc(1, 1, ADDU, BEQ, 32'h600, 0, 2'd2, 1, 1);
        n_tests++;
        if ({empty_o, valid1_o, inst1_o} !== {1'b1, 1'b0, 32'd0} || obs_s !== model_outputs()) begin
            n_fail++; $display("FAIL flush_priority: got %h want %h", obs_s, model_outputs());
        end
    endtask

    task automatic test_random();
        bit p1, p2, st, br, fl;
        logic [1:0] pn;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                test_reset();
            end else begin
                p1 = ($urandom_range(0, 3) != 0);
                p2 = p1 && ($urandom_range(0, 1) != 0);
                st = ($urandom_range(0, 4) == 0);
                pn = (c % 400 < 200) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 2));
                br = ($urandom_range(0, 24) == 0);
                fl = ($urandom_range(0, 149) == 0);
                cyc(p1, p2, pick_inst(), pick_inst(), $urandom & 32'hFFFF_FFFC, st, pn, br, fl);
                n_tests++;
                if (obs_s !== model_outputs()) begin
                    n_fail++; $display("FAIL random_c%0d: got %h want %h", c, obs_s, model_outputs());
                end
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_dual_push();
        test_delay_slot();
        test_keep_one();
        test_full();
        test_wrap();
        test_flush_priority();
        test_random();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
